// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default width for the multiply/divide unit
package muldiv_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: two's-complement negate-on-request, used for operand magnitudes and result sign correction
module muldiv_sign_fix import muldiv_pkg::*; #(
    parameter int W = DEFAULT_WIDTH
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide owning HI and LO; MULDIV_EARLY_OUT_EN enables multiply early exit
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif
    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, sh_q, sh_d;
    logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
    logic               sa, sb, b_zero, skip, last, ok;
    logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, new_rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     top;

    assign sa     = op[0] & A[WIDTH-1];
    assign sb     = op[0] & B[WIDTH-1];
    assign b_zero = (B == '0);
    assign skip   = b_zero & (op[1] | EARLY_OUT);

    muldiv_sign_fix #(.W(WIDTH))   u_mag_a (.val_i(A), .neg_i(sa), .res_o(mag_a));
    muldiv_sign_fix #(.W(WIDTH))   u_mag_b (.val_i(B), .neg_i(sb), .res_o(mag_b));
    muldiv_sign_fix #(.W(2*WIDTH)) u_prod  (.val_i(acc_q), .neg_i(neg_q), .res_o(prod));
    muldiv_sign_fix #(.W(WIDTH))   u_quo   (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .res_o(quo));
    muldiv_sign_fix #(.W(WIDTH))   u_rem   (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(rneg_q), .res_o(rem));

    // restoring-divide step: shifted partial remainder against the divisor magnitude
    assign top     = acc_q[2*WIDTH-1:WIDTH-1];
    assign ok      = top >= {1'b0, b_q};
    assign new_rem = ok ? WIDTH'(top - {1'b0, b_q}) : top[WIDTH-1:0];
    // last iteration: counter exhausted, or (early-out) no multiplier bits left after this one
    assign last    = (cnt_q == CNT_W'(WIDTH - 1)) | (EARLY_OUT & ~op_q[1] & (b_q[WIDTH-1:1] == '0));

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // next-state, datapath and HI/LO update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
                    b_d     = mag_b;
                    sh_d    = {{WIDTH{1'b0}}, mag_a};
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    acc_d   = op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
                    state_d = skip ? ST_FIX : ST_CALC;
                    if (op[1] && b_zero) begin
                        acc_d  = {A, {WIDTH{1'b1}}};
                        neg_d  = 1'b0;
                        rneg_d = 1'b0;
                    end
                end else begin
                    hi_d = wr_hi ? wdata : hi_q;
                    lo_d = wr_lo ? wdata : lo_q;
                end
            end
            ST_CALC: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? ST_FIX : ST_CALC;
                if (op_q[1]) begin
                    acc_d = {new_rem, acc_q[WIDTH-2:0], ok};
                end else begin
                    acc_d = b_q[0] ? acc_q + sh_q : acc_q;
                    sh_d  = sh_q << 1;
                    b_d   = b_q >> 1;
                end
            end
            default: begin
                {hi_d, lo_d} = op_q[1] ? {rem, quo} : prod;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, hand sequences and random ops against an arithmetic reference model
module tb_muldiv_unit;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif
    logic        clk = 0, rst_n = 0, start = 0, wr_hi = 0, wr_lo = 0;
    logic [1:0]  op = 0;
    logic [31:0] A = 0, B = 0, wdata = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a, b, e_hi, e_lo;
        int          l_def, l_eo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00) return {32'b0, a} * {32'b0, b};
        if (o == 2'b01) return 64'(sa * sb);
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (o == 2'b10) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int idx;
        if (o[1]) return (b == 0) ? 1 : 33;
        if (!EO) return 33;
        m = (o[0] && b[31]) ? -b : b;
        if (m == 0) return 1;
        idx = 0;
        for (int i = 0; i < 32; i++) if (m[i]) idx = i;
        return 2 + idx;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    task automatic finish_op(input string tag, input logic [63:0] exp, input int lat);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " done"}, {31'b0, done}, 32'd1);
        chk({tag, " hi"}, hi, exp[63:32]);
        chk({tag, " lo"}, lo, exp[31:0]);
        @(negedge clk);
        chk({tag, " done_fall"}, {31'b0, done}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        @(negedge clk);
        start = 1; op = o; A = a; B = b;
        @(negedge clk);
        start = 0;
        finish_op(tag, exp, lat);
    endtask

    initial begin
        vec_t vt[12];
        logic [63:0] e;
        logic [31:0] ra, rb, keep_lo;
        logic [1:0]  ro;
        vt[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
        vt[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 4};
        vt[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
        vt[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33};
        vt[4]  = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1, 1};
        vt[5]  = '{2'b00, 32'h12345678, 32'h00000001, 32'h00000000, 32'h12345678, 33, 2};
        vt[6]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       33, 33};
        vt[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 33};
        vt[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 33};
        vt[9]  = '{2'b11, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1, 1};
        vt[10] = '{2'b00, 32'h00010000, 32'h00000000, 32'h00000000, 32'h00000000, 33, 1};
        vt[11] = '{2'b01, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 33, 2};

        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst_n = 1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vt[i].o, vt[i].a, vt[i].b, {vt[i].e_hi, vt[i].e_lo},
                   EO ? vt[i].l_eo : vt[i].l_def);

        // second start at cycle 10 and wr_lo at cycle 12 of a MULTU are both ignored
        @(negedge clk);
        start = 1; op = 2'b00; A = 32'hDEADBEEF; B = 32'h80012345;
        wr_lo = 1; wdata = 32'h0BADF00D;
        @(negedge clk);
        start = 0; wr_lo = 0;
        for (int c = 1; c <= 13; c++) begin
            start = (c == 10);
            op    = 2'b11; A = 32'd99; B = 32'd3;
            wr_lo = (c == 12);
            @(negedge clk);
        end
        start = 0; wr_lo = 0;
        begin
            int n = 13;
            while (busy && n < 200) begin
                n++;
                @(negedge clk);
            end
            e = model(2'b00, 32'hDEADBEEF, 32'h80012345);
            chk("ignore latency", 32'(n), 32'd33);
            chk("ignore done", {31'b0, done}, 32'd1);
            chk("ignore hi", hi, e[63:32]);
            chk("ignore lo", lo, e[31:0]);
        end
        @(negedge clk);
        chk("ignore restart busy", {31'b0, busy}, 32'd0);

        keep_lo = lo;
        wr_hi = 1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        wr_hi = 0;
        chk("mthi hi", hi, 32'hA5A5A5A5);
        chk("mthi lo", lo, keep_lo);
        chk("mthi done", {31'b0, done}, 32'd0);
        chk("mthi busy", {31'b0, busy}, 32'd0);
        wr_hi = 1; wr_lo = 1; wdata = 32'h3C3C3C3C;
        @(negedge clk);
        wr_hi = 0; wr_lo = 0;
        chk("both hi", hi, 32'h3C3C3C3C);
        chk("both lo", lo, 32'h3C3C3C3C);
        chk("both done", {31'b0, done}, 32'd0);

        // reset pulse in cycle 15 of a DIVU
        @(negedge clk);
        start = 1; op = 2'b10; A = 32'd1000; B = 32'd3;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        chk("pre-reset busy", {31'b0, busy}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid reset busy", {31'b0, busy}, 32'd0);
        chk("mid reset done", {31'b0, done}, 32'd0);
        chk("mid reset hi", hi, 32'd0);
        chk("mid reset lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1; start = 1; op = 2'b00; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 0;
        chk("post-reset accept", {31'b0, busy}, 32'd1);
        finish_op("post-reset", 64'd15, exp_lat(2'b00, 32'd5));

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick32();
            rb = pick32();
            run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb), exp_lat(ro, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
